// File: rtl/pal_clken_gen_pkg.sv
// Shared definitions for the PAL clock-enable generator.
// Holds the reset-sequencer states and the nominal PAL timing constants.
package pal_clken_gen_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } clken_state_t;

   // 56.75 MHz PLL output divided by 32 gives the 1.7734 MHz PAL phi2 rate
   localparam int PAL_CLK_HZ  = 56_750_000;
   localparam int PAL_CPU_DIV = 32;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pal_clken_gen_sync2.sv
// Two-flop single-bit synchronizer for signals arriving from another clock domain.
// Both flops clear on the synchronous reset so a stale level never leaks through.
module pal_clken_gen_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pal_clken_gen.sv
// PAL clock-enable generator: sequences the core reset off a stable PLL lock,
// then divides the system clock into CPU and colour clock enables.
module pal_clken_gen
   import pal_clken_gen_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int CPU_DIV            = PAL_CPU_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic pll_locked,
   input  logic halt,
   output logic sys_reset,
   output logic running,
   output logic cpu_enable,
   output logic cpu_enable_next,
   output logic colour_enable
);

   localparam int PW      = $clog2(CPU_DIV);
   localparam int CNT_MAX = max_int(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
   localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);
   localparam logic [PW-1:0] CPU_LAST  = PW'(CPU_DIV - 1);
   localparam logic [PW-1:0] CPU_PRE   = PW'(CPU_DIV - 2);

   logic         locked_s;
   clken_state_t state, state_next;
   logic [CW-1:0] count, count_next;
   logic [PW-1:0] phase, phase_next;
   logic         advance;
   logic         cpu_en_d, cpu_next_d, colour_en_d;

   pal_clken_gen_sync2 u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // Lock loss overrides every other transition once we have left WAIT_LOCK
   always_comb begin
      state_next = state;
      count_next = count;
      if (state != WAIT_LOCK && !locked_s) begin
         state_next = WAIT_LOCK;
         count_next = '0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               count_next = '0;
               if (locked_s)
                  state_next = STABILIZE;
            end
            STABILIZE: begin
               if (count == STAB_LAST) begin
                  state_next = HOLD;
                  count_next = '0;
               end else begin
                  count_next = count + CW'(1);
               end
            end
            HOLD: begin
               if (count == HOLD_LAST) begin
                  state_next = RUN;
                  count_next = '0;
               end else begin
                  count_next = count + CW'(1);
               end
            end
            RUN:     count_next = '0;
            default: begin
               state_next = WAIT_LOCK;
               count_next = '0;
            end
         endcase
      end
   end

   // The phase only moves while staying in RUN; entering RUN starts it from zero
   always_comb begin
      phase_next  = '0;
      advance     = 1'b0;
      if (state == RUN && state_next == RUN) begin
         if (halt) begin
            phase_next = phase;
         end else begin
            phase_next = phase + PW'(1);
            advance    = 1'b1;
         end
      end
      cpu_en_d    = advance && (phase_next == CPU_LAST);
      cpu_next_d  = advance && (phase_next == CPU_PRE);
      colour_en_d = advance && (&phase_next[PW-2:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= WAIT_LOCK;
         count           <= '0;
         phase           <= '0;
         sys_reset       <= 1'b1;
         running         <= 1'b0;
         cpu_enable      <= 1'b0;
         cpu_enable_next <= 1'b0;
         colour_enable   <= 1'b0;
      end else begin
         state           <= state_next;
         count           <= count_next;
         phase           <= phase_next;
         sys_reset       <= (state_next != RUN);
         running         <= (state_next == RUN);
         cpu_enable      <= cpu_en_d;
         cpu_enable_next <= cpu_next_d;
         colour_enable   <= colour_en_d;
      end
   end

endmodule

// File: tb/tb_pal_clken_gen.sv
// Scoreboard bench for pal_clken_gen: a lock-streak/phase-count reference model
// predicts every cycle's outputs, with directed timing checks around it.
module tb_pal_clken_gen;

   localparam int LSC        = 8;
   localparam int RHC        = 4;
   localparam int DIV        = 32;
   localparam int RUN_STREAK = 1 + LSC + RHC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pll_locked = 1'b0;
   logic halt = 1'b0;
   logic sys_reset, running, cpu_enable, cpu_enable_next, colour_enable;

   typedef struct packed {
      logic sys_reset;
      logic running;
      logic cpu_enable;
      logic cpu_enable_next;
      logic colour_enable;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   logic m_sync_a = 1'b0;
   logic m_sync_b = 1'b0;
   int   streak = 0;
   int   adv = 0;

   always #5 clk = ~clk;

   pal_clken_gen #(
      .LOCK_STABLE_CYCLES (LSC),
      .RESET_HOLD_CYCLES  (RHC),
      .CPU_DIV            (DIV)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .halt            (halt),
      .sys_reset       (sys_reset),
      .running         (running),
      .cpu_enable      (cpu_enable),
      .cpu_enable_next (cpu_enable_next),
      .colour_enable   (colour_enable)
   );

   // Reference: RUN after RUN_STREAK consecutive synchronized-lock samples;
   // enables follow from the count of un-halted RUN cycles.
   task automatic model_edge(input logic r, input logic p, input logic h);
      exp_t e;
      logic ls, prev_run, run;
      e = '0;
      if (r) begin
         m_sync_a    = 1'b0;
         m_sync_b    = 1'b0;
         streak      = 0;
         adv         = 0;
         e.sys_reset = 1'b1;
      end else begin
         ls       = m_sync_b;
         m_sync_b = m_sync_a;
         m_sync_a = p;
         prev_run = (streak >= RUN_STREAK);
         streak   = ls ? streak + 1 : 0;
         if (streak > RUN_STREAK)
            streak = RUN_STREAK;
         run = (streak >= RUN_STREAK);
         if (run && prev_run && !h) begin
            adv++;
            e.cpu_enable      = ((adv % DIV) == DIV - 1);
            e.cpu_enable_next = ((adv % DIV) == DIV - 2);
            e.colour_enable   = ((adv % (DIV / 2)) == DIV / 2 - 1);
         end
         if (!run)
            adv = 0;
         e.sys_reset = !run;
         e.running   = run;
      end
      sb.push_back(e);
   endtask

   task automatic apply_stimulus(input logic r, input logic p, input logic h);
      @(negedge clk);
      rst        = r;
      pll_locked = p;
      halt       = h;
      @(posedge clk);
      model_edge(r, p, h);
   endtask

   task automatic check_output(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e, g;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         g = {sys_reset, running, cpu_enable, cpu_enable_next, colour_enable};
         tests++;
         if (g !== e) begin
            fails++;
            $display("[TB] FAIL outputs t=%0t got %b expected %b (sys_reset,running,cpu,cpu_next,colour)",
                     $time, g, e);
         end
      end
   end

   task automatic count_to_run(output int n);
      n = 200;
      for (int i = 0; i < 200; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b0);
         #1;
         if (sys_reset == 1'b0) begin
            n = i + 1;
            break;
         end
      end
   endtask

   task automatic count_to_cpu(output int n);
      n = 200;
      for (int i = 0; i < 200; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b0);
         #1;
         if (cpu_enable == 1'b1) begin
            n = i + 1;
            break;
         end
      end
   endtask

   task automatic count_to_lock_loss(output int n);
      n = 50;
      for (int i = 0; i < 50; i++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0);
         #1;
         if (sys_reset == 1'b1) begin
            n = i + 1;
            break;
         end
      end
   endtask

   task automatic run_to_phase(input int ph);
      for (int i = 0; i < 3 * DIV; i++) begin
         if ((adv % DIV) == ph)
            break;
         apply_stimulus(1'b0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      int n;
      repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);

      count_to_run(n);
      check_output("lock_to_run", n, RUN_STREAK + 2);
      count_to_cpu(n);
      check_output("first_cpu", n, DIV - 1);

      repeat (1000) apply_stimulus(1'b0, 1'b1, 1'b0);

      run_to_phase(10);
      check_output("halt_phase", adv % DIV, 10);
      repeat (10) apply_stimulus(1'b0, 1'b1, 1'b1);
      count_to_cpu(n);
      check_output("halt_resume", n, 21);

      run_to_phase(20);
      count_to_lock_loss(n);
      check_output("lock_loss", n, 3);
      repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0);
      count_to_run(n);
      check_output("relock", n, RUN_STREAK + 2);

      apply_stimulus(1'b1, 1'b1, 1'b0);
      repeat (8) apply_stimulus(1'b0, 1'b1, 1'b0);
      repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);
      count_to_run(n);
      check_output("glitch_restart", n, RUN_STREAK + 2);

      run_to_phase(17);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      #1;
      check_output("rst_sys_reset", sys_reset, 1);
      count_to_run(n);
      check_output("rst_recover", n, RUN_STREAK + 2);

      for (int i = 0; i < 3000; i++) begin
         apply_stimulus(($urandom_range(0, 499) == 0),
                        ($urandom_range(0, 149) != 0),
                        ($urandom_range(0, 7) == 0));
      end

      repeat (3) @(negedge clk);
      #1;
      check_output("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pal_clken_gen.md
PAL_CLKEN_GEN -- requirements
Module: pal_clken_gen

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset sequencing proceeds (min 2).
REQ-002 Parameter RESET_HOLD_CYCLES, default 16: cycles sys_reset stays high after lock is declared stable (min 1).
REQ-003 Parameter CPU_DIV, default 32: system clocks per CPU enable (56.75 MHz / 32 = 1.7734 MHz PAL phi2); power of two, 4..64.
REQ-004 clk  input  1  system clock, driven by the PAL PLL output (56.75 MHz); the block's only clock.
REQ-005 rst  input  1  reset, synchronous to clk, active-high.
REQ-006 pll_locked  input  1  PLL lock indication, asynchronous to clk.
REQ-007 halt  input  1  synchronous; freezes the enable phase while high.
REQ-008 sys_reset  output  1  registered active-high reset for downstream Atari core logic.
REQ-009 running  output  1  registered; high in state RUN.
REQ-010 cpu_enable  output  1  registered single-cycle CPU clock enable.
REQ-011 cpu_enable_next  output  1  registered; high exactly one cycle before each cpu_enable.
REQ-012 colour_enable  output  1  registered single-cycle enable at 2x the cpu_enable rate.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer (locked_s) before any use; no other logic samples pll_locked.
REQ-014 FSM states: WAIT_LOCK, STABILIZE, HOLD, RUN; one shared cycle counter.
REQ-015 WAIT_LOCK: counter=0; locked_s=1 -> STABILIZE.
REQ-016 STABILIZE: counter increments each cycle; counter==LOCK_STABLE_CYCLES-1 with locked_s=1 -> HOLD, counter cleared.
REQ-017 HOLD: counter increments; counter==RESET_HOLD_CYCLES-1 -> RUN.
REQ-018 locked_s=0 in STABILIZE, HOLD or RUN -> WAIT_LOCK next cycle, counter cleared; this has priority over every other transition.
REQ-019 sys_reset SHALL be 1 in every state except RUN; running = (state==RUN); both registered, changing on the clk edge the state changes.
REQ-020 Phase counter p (log2(CPU_DIV) bits) SHALL be 0 outside RUN; in RUN it increments modulo CPU_DIV each cycle halt=0 and holds when halt=1.
REQ-021 Indexing the first RUN cycle (sys_reset low) as cycle 0 with halt=0: cpu_enable high in cycles CPU_DIV-1, 2*CPU_DIV-1, ...; cpu_enable_next in cycles CPU_DIV-2, 2*CPU_DIV-2, ...; colour_enable in cycles CPU_DIV/2-1, CPU_DIV-1, 3*CPU_DIV/2-1, ...
REQ-022 All enables SHALL be 0 in any cycle halt=1 and in any cycle outside RUN; after halt drops, the sequence resumes from the frozen phase with no pulse lost or duplicated.
REQ-023 cpu_enable and cpu_enable_next SHALL never be high in the same cycle; cpu_enable coincides with every second colour_enable.
REQ-024 Lock loss in RUN: sys_reset=1, running=0, all enables 0 and p=0 in the cycle after locked_s falls.

Reset
REQ-025 rst=1 SHALL force state=WAIT_LOCK, counters=0, synchronizer flops=0, sys_reset=1, running=0, all enables=0 on the next clk edge, and rst has priority over all FSM behaviour including mid-RUN.

Structure
REQ-026 Shared package holds the FSM state enumeration and the PAL constants (CPU_DIV=32, 56.75 MHz nominal frequency).
REQ-027 One sub-module: sync2 (2-flop bit synchronizer), used for pll_locked.

Verification (bench parameters LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, CPU_DIV=32)
REQ-028 pll_locked held 1 from reset release -> sys_reset falls exactly 2+1+8+4 cycles (±1 for documented FSM edge) later, identically on every run; first cpu_enable 31 cycles after that.
REQ-029 Steady RUN for 1000 cycles -> cpu_enable period 32, colour_enable period 16, cpu_enable_next one cycle before every cpu_enable, no overlap.
REQ-030 pll_locked glitches low for 3 cycles during STABILIZE at count 5 -> FSM returns to WAIT_LOCK and the full 8-cycle stabilize count restarts.
REQ-031 pll_locked drops in RUN at phase 20 -> sys_reset high and enables 0 three cycles later (2 sync + 1); relock repeats REQ-028 timing.
REQ-032 halt=1 for 10 cycles at p=10 -> no enables during halt; next cpu_enable 21 cycles after halt falls.
REQ-033 rst=1 for one cycle mid-RUN -> all outputs at reset values next cycle; recovery matches REQ-028.
